bcp_engine: RTL and testbench
=============================

// Module: bcp_engine
// PURPOSE
//  Responder side of the control<->BCP interface. Accepts the clause-index stream issued by control
//  (bcp_en/bcp_clause_idx), fetches each clause, evaluates its literals against the var state table,
//  pushes unit implications into the imply FIFO and flags conflicts. Reports bcp_busy until all
//  queued clauses are evaluated. Sits between control, clause database, var state table and imply FIFO.
// PARAMETERS
//  LITS      3                  literals per clause slot (unused slots have valid=0)
//  QDEPTH    16                 clause-index queue depth (power of 2, >= max clauses per variable)
//  `MAX_VARS_BITS / `MAX_CLAUSES_BITS   from sysdefs.svh
// PORTS
//  clock           in   1      system clock
//  reset           in   1      asynchronous, active-low reset
//  reset_bcp       in   1      sync clear: flush queue, abort eval, clear conflict
//  bcp_en          in   1      clause index valid this cycle
//  bcp_clause_idx  in   CB     clause index (CB=`MAX_CLAUSES_BITS)
//  bcp_busy        out  1      engine has work pending (combinational)
//  conflict        out  1      sticky: a clause evaluated all-false
//  q_overflow      out  1      sticky: bcp_en seen with queue full (index dropped)
//  cdb_read        out  1      clause DB read strobe
//  cdb_addr        out  CB     clause DB address
//  cdb_lits        in   LITS*(VB+2)  clause literals {valid,neg,var}, valid 1 cycle after cdb_read
//  vs_read         out  1      var state read strobe
//  vs_var          out  VB     var to read (VB=`MAX_VARS_BITS)
//  vs_val          in   1      value, valid 1 cycle after vs_read
//  vs_unassign     in   1      1 = unassigned, valid 1 cycle after vs_read
//  full_imply      in   1      imply FIFO full
//  push_imply      out  1      push strobe (single cycle per implication)
//  var_in_imply    out  VB     implied var
//  val_in_imply    out  1      implied value (= ~neg of unit literal)
//  type_in_imply   out  1      always 1 (implied)
// BEHAVIOUR
//  Reset (reset=0): all outputs 0, queue empty, FSM IDLE; applies immediately, mid-operation included.
//  Queue: bcp_en && !full -> enqueue; bcp_en && full -> drop, set q_overflow. Order preserved.
//  bcp_busy = bcp_en | queue non-empty | (state != IDLE). Deasserts the cycle the last clause retires.
//  FSM:
//   IDLE    : queue non-empty & !conflict -> dequeue, cdb_read=1, cdb_addr=idx -> LOAD.
//   LOAD    : capture cdb_lits; k=0, n_unassigned=0 -> EVAL.
//   EVAL    : per valid literal: vs_read cycle then result cycle (2 cycles/literal).
//             lit value = vs_val ^ neg. assigned & true -> clause satisfied, stop early -> IDLE.
//             unassigned -> n_unassigned++ (saturate at 2), remember literal. Invalid slot -> skip, 0 cycles.
//             after last literal -> CLASSIFY.
//   CLASSIFY: n_unassigned==0 -> conflict<=1 -> IDLE. ==1 -> PUSH. >=2 -> IDLE.
//   PUSH    : hold var/val; push_imply=1 only in a cycle with !full_imply, then -> IDLE.
//  Conflict: sticky until reset_bcp; while set, no dequeue, queue flushed, bcp_busy falls once IDLE.
//  reset_bcp: next cycle FSM IDLE, queue empty, conflict=0, q_overflow=0, pending push abandoned.
//   reset_bcp & bcp_en same cycle: reset_bcp wins, index dropped.
//  Duplicate implications are not filtered (control/trace resolve them).
//  Clause with zero valid literals = conflict.
//  Queue pointers are log2(QDEPTH) bits with wrap; count is log2(QDEPTH)+1 bits.
// STRUCTURE
//  sat_pkg: lit_t struct {valid,neg,var}, bcp_state_t enum, LITS/QDEPTH defaults.
//  Sub-module bcp_idx_fifo (QDEPTH x CB, sync, flush input) for the index queue; FSM + literal eval inline.
// TESTING
//  1 clause (x1 | ~x2 | x3), x1=0,x2=1,x3 unassigned -> one push var=3 val=1 type=1; conflict=0.
//  2 clause (x1 | x2), x1=0,x2=0 -> conflict=1 sticky, no push, queued indices flushed, busy=0.
//  3 clause (x4 | x5 | x6), x4=1 -> only one vs_read issued, no push, IDLE after 3 cycles.
//  4 16 back-to-back indices, all unit, full_imply=1 for 5 cycles -> pushes stall, order kept; 17th -> q_overflow.
//  5 reset_bcp during EVAL -> IDLE next cycle, no push, conflict/busy 0; reset=0 mid-PUSH -> all outputs 0 at once.
//  6 bcp_en single index while IDLE -> bcp_busy=1 same cycle, held until retire.

Source files
------------

// File: rtl/sat_pkg.sv
// Shared types and sizing for the BCP engine: literal layout, FSM states, defaults.
package sat_pkg;

    localparam int unsigned MAX_VARS_BITS    = 8;
    localparam int unsigned MAX_CLAUSES_BITS = 8;
    localparam int unsigned VB               = MAX_VARS_BITS;
    localparam int unsigned CB               = MAX_CLAUSES_BITS;
    localparam int unsigned LIT_W            = VB + 2;
    localparam int unsigned LITS_DEF         = 3;
    localparam int unsigned QDEPTH_DEF       = 16;

    // vid is the variable number (var is reserved in SystemVerilog)
    typedef struct packed {
        logic          valid;
        logic          neg;
        logic [VB-1:0] vid;
    } lit_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EVAL_RD,
        S_EVAL_CHK,
        S_CLASSIFY,
        S_PUSH
    } bcp_state_t;

endpackage

// File: rtl/bcp_idx_fifo.sv
// Synchronous show-ahead FIFO for clause indices with flush; pointers wrap, count is one bit wider.
module bcp_idx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic         full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_wr;
    logic          do_rd;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/bcp_engine.sv
// BCP responder: queues clause indices, fetches and evaluates each clause against the
// variable state table, pushes unit implications and flags conflicts.
module bcp_engine
    import sat_pkg::*;
#(
    parameter int unsigned LITS   = LITS_DEF,
    parameter int unsigned QDEPTH = QDEPTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  reset_bcp,
    input  logic                  bcp_en,
    input  logic [CB-1:0]         bcp_clause_idx,
    output logic                  bcp_busy,
    output logic                  conflict,
    output logic                  q_overflow,
    output logic                  cdb_read,
    output logic [CB-1:0]         cdb_addr,
    input  logic [LITS*LIT_W-1:0] cdb_lits,
    output logic                  vs_read,
    output logic [VB-1:0]         vs_var,
    input  logic                  vs_val,
    input  logic                  vs_unassign,
    input  logic                  full_imply,
    output logic                  push_imply,
    output logic [VB-1:0]         var_in_imply,
    output logic                  val_in_imply,
    output logic                  type_in_imply
);

    localparam int unsigned KW = (LITS > 1) ? $clog2(LITS) : 1;

    bcp_state_t    state, state_nxt;
    lit_t          lits_q  [LITS];
    lit_t          lits_in [LITS];
    logic [LITS-1:0] valid_src;
    logic [KW-1:0] k_q, k_nxt;
    logic [1:0]    n_un_q, n_un_nxt;
    logic [VB-1:0] unit_var_q, unit_var_nxt;
    logic          unit_val_q, unit_val_nxt;
    logic          load_lits;
    logic          set_conflict;
    logic          deq;
    logic          q_empty;
    logic          q_full;
    logic [CB-1:0] q_head;
    logic          nv_found;
    logic [KW-1:0] nv_idx;
    int unsigned   nv_from;

    // Conflict keeps the queue flushed; flushing on the setting cycle lets busy drop on the next edge
    bcp_idx_fifo #(
        .DEPTH (QDEPTH),
        .W     (CB)
    ) u_idx_fifo (
        .clock   (clock),
        .reset   (reset),
        .flush   (reset_bcp | conflict | set_conflict),
        .wr_en   (bcp_en & ~reset_bcp),
        .wr_data (bcp_clause_idx),
        .rd_en   (deq),
        .rd_data (q_head),
        .empty   (q_empty),
        .full    (q_full)
    );

    assign bcp_busy = reset & (bcp_en | ~q_empty | (state != S_IDLE));

    always_comb begin
        for (int unsigned i = 0; i < LITS; i++) begin
            lits_in[i]   = lit_t'(cdb_lits[i*LIT_W +: LIT_W]);
            valid_src[i] = (state == S_LOAD) ? lits_in[i].valid : lits_q[i].valid;
        end
    end

    // Next valid slot at or after nv_from; invalid slots are skipped without spending a cycle
    always_comb begin
        nv_found = 1'b0;
        nv_idx   = '0;
        nv_from  = (state == S_LOAD) ? 0 : 32'(k_q) + 32'd1;
        for (int unsigned i = 0; i < LITS; i++) begin
            if (!nv_found && i >= nv_from && valid_src[i]) begin
                nv_found = 1'b1;
                nv_idx   = KW'(i);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            k_q        <= '0;
            n_un_q     <= '0;
            unit_var_q <= '0;
            unit_val_q <= 1'b0;
            conflict   <= 1'b0;
            q_overflow <= 1'b0;
            lits_q     <= '{default: '0};
        end else if (reset_bcp) begin
            state      <= S_IDLE;
            conflict   <= 1'b0;
            q_overflow <= 1'b0;
        end else begin
            state      <= state_nxt;
            k_q        <= k_nxt;
            n_un_q     <= n_un_nxt;
            unit_var_q <= unit_var_nxt;
            unit_val_q <= unit_val_nxt;
            if (load_lits)       lits_q     <= lits_in;
            if (set_conflict)    conflict   <= 1'b1;
            if (bcp_en && q_full) q_overflow <= 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        k_nxt         = k_q;
        n_un_nxt      = n_un_q;
        unit_var_nxt  = unit_var_q;
        unit_val_nxt  = unit_val_q;
        load_lits     = 1'b0;
        set_conflict  = 1'b0;
        deq           = 1'b0;
        cdb_read      = 1'b0;
        cdb_addr      = '0;
        vs_read       = 1'b0;
        vs_var        = '0;
        push_imply    = 1'b0;
        var_in_imply  = '0;
        val_in_imply  = 1'b0;
        type_in_imply = 1'b0;
        case (state)
            S_IDLE: begin
                if (!q_empty && !conflict && !reset_bcp) begin
                    deq       = 1'b1;
                    cdb_read  = 1'b1;
                    cdb_addr  = q_head;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                load_lits = 1'b1;
                n_un_nxt  = '0;
                k_nxt     = nv_idx;
                state_nxt = nv_found ? S_EVAL_RD : S_CLASSIFY;
            end
            S_EVAL_RD: begin
                vs_read   = 1'b1;
                vs_var    = lits_q[k_q].vid;
                state_nxt = S_EVAL_CHK;
            end
            S_EVAL_CHK: begin
                if (!vs_unassign && (vs_val ^ lits_q[k_q].neg)) begin
                    state_nxt = S_IDLE;
                end else begin
                    if (vs_unassign) begin
                        if (n_un_q != 2'd2) n_un_nxt = n_un_q + 2'd1;
                        unit_var_nxt = lits_q[k_q].vid;
                        unit_val_nxt = ~lits_q[k_q].neg;
                    end
                    k_nxt     = nv_idx;
                    state_nxt = nv_found ? S_EVAL_RD : S_CLASSIFY;
                end
            end
            S_CLASSIFY: begin
                if (n_un_q == 2'd0) begin
                    set_conflict = 1'b1;
                    state_nxt    = S_IDLE;
                end else if (n_un_q == 2'd1) begin
                    state_nxt = S_PUSH;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_PUSH: begin
                var_in_imply  = unit_var_q;
                val_in_imply  = unit_val_q;
                type_in_imply = 1'b1;
                if (!full_imply && !reset_bcp) begin
                    push_imply = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_bcp_engine.sv
// Directed self-checking bench for bcp_engine with behavioural clause DB and var state models.
module tb_bcp_engine;

    logic        clock;
    logic        reset;
    logic        reset_bcp;
    logic        bcp_en;
    logic [7:0]  bcp_clause_idx;
    logic        bcp_busy;
    logic        conflict;
    logic        q_overflow;
    logic        cdb_read;
    logic [7:0]  cdb_addr;
    logic [29:0] cdb_lits;
    logic        vs_read;
    logic [7:0]  vs_var;
    logic        vs_val;
    logic        vs_unassign;
    logic        full_imply;
    logic        push_imply;
    logic [7:0]  var_in_imply;
    logic        val_in_imply;
    logic        type_in_imply;

    logic [29:0] db      [256];
    logic        var_val [256];
    logic        var_un  [256];
    logic [9:0]  pushes  [$];
    int          vs_cnt;
    int          cdb_cnt;
    int          bad_push;
    int          n_checks;
    int          n_fail;

    bcp_engine #(
        .LITS   (3),
        .QDEPTH (16)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .reset_bcp      (reset_bcp),
        .bcp_en         (bcp_en),
        .bcp_clause_idx (bcp_clause_idx),
        .bcp_busy       (bcp_busy),
        .conflict       (conflict),
        .q_overflow     (q_overflow),
        .cdb_read       (cdb_read),
        .cdb_addr       (cdb_addr),
        .cdb_lits       (cdb_lits),
        .vs_read        (vs_read),
        .vs_var         (vs_var),
        .vs_val         (vs_val),
        .vs_unassign    (vs_unassign),
        .full_imply     (full_imply),
        .push_imply     (push_imply),
        .var_in_imply   (var_in_imply),
        .val_in_imply   (val_in_imply),
        .type_in_imply  (type_in_imply)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Registered memory models: data valid one cycle after the read strobe
    always @(posedge clock) begin
        if (cdb_read) cdb_lits <= db[cdb_addr];
        if (vs_read) begin
            vs_val      <= var_val[vs_var];
            vs_unassign <= var_un[vs_var];
        end
    end

    always @(negedge clock) begin
        if (push_imply) pushes.push_back({type_in_imply, val_in_imply, var_in_imply});
        if (push_imply && full_imply) bad_push++;
        if (vs_read) vs_cnt++;
        if (cdb_read) cdb_cnt++;
    end

    function automatic logic [9:0] lit(input logic v, input logic n, input logic [7:0] x);
        return {v, n, x};
    endfunction

    task automatic send_one(input logic [7:0] idx);
        bcp_en = 1'b1;
        bcp_clause_idx = idx;
        @(posedge clock); #1;
        bcp_en = 1'b0;
    endtask

    task automatic wait_idle(input int max, output int n);
        n = 0;
        while (bcp_busy && n < max) begin
            @(posedge clock); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if ({bcp_busy, conflict, q_overflow, cdb_read, vs_read, push_imply, type_in_imply} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {bcp_busy, conflict, q_overflow, cdb_read, vs_read, push_imply, type_in_imply});
        end
        reset = 1'b1;
        @(posedge clock); #1;
        n_checks++;
        if (bcp_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_busy: got %b expected 0", bcp_busy);
        end
    endtask

    task automatic test_unit_push;
        int n;
        pushes.delete();
        bcp_en = 1'b1;
        bcp_clause_idx = 8'd1;
        #1;
        n_checks++;
        if (bcp_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_same_cycle: got %b expected 1", bcp_busy);
        end
        @(posedge clock); #1;
        bcp_en = 1'b0;
        wait_idle(50, n);
        n = n + 1;
        n_checks++;
        if (n !== 11) begin
            n_fail++;
            $display("FAIL unit_busy_cycles: got %0d expected 11", n);
        end
        n_checks++;
        if (pushes.size() !== 1) begin
            n_fail++;
            $display("FAIL unit_push_count: got %0d expected 1", pushes.size());
        end else begin
            n_checks++;
            if (pushes[0] !== {1'b1, 1'b1, 8'd3}) begin
                n_fail++;
                $display("FAIL unit_push_value: got %h expected %h", pushes[0], {1'b1, 1'b1, 8'd3});
            end
        end
        n_checks++;
        if (conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL unit_conflict: got %b expected 0", conflict);
        end
    endtask

    task automatic test_satisfied;
        int n;
        int v0;
        pushes.delete();
        v0 = vs_cnt;
        bcp_en = 1'b1;
        bcp_clause_idx = 8'd3;
        @(posedge clock); #1;
        bcp_en = 1'b0;
        wait_idle(50, n);
        n = n + 1;
        n_checks++;
        if (n !== 5) begin
            n_fail++;
            $display("FAIL sat_busy_cycles: got %0d expected 5", n);
        end
        n_checks++;
        if (vs_cnt - v0 !== 1) begin
            n_fail++;
            $display("FAIL sat_vs_reads: got %0d expected 1", vs_cnt - v0);
        end
        n_checks++;
        if (pushes.size() !== 0) begin
            n_fail++;
            $display("FAIL sat_push_count: got %0d expected 0", pushes.size());
        end
    endtask

    task automatic test_conflict;
        int n;
        int c0;
        pushes.delete();
        c0 = cdb_cnt;
        bcp_en = 1'b1;
        bcp_clause_idx = 8'd2;
        @(posedge clock); #1;
        bcp_clause_idx = 8'd1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        bcp_en = 1'b0;
        wait_idle(50, n);
        n = n + 3;
        n_checks++;
        if (n !== 8) begin
            n_fail++;
            $display("FAIL conflict_busy_cycles: got %0d expected 8", n);
        end
        n_checks++;
        if (conflict !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_set: got %b expected 1", conflict);
        end
        send_one(8'd1);
        repeat (5) @(posedge clock);
        #1;
        n_checks++;
        if ({conflict, bcp_busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL conflict_sticky_busy: got %b expected 10", {conflict, bcp_busy});
        end
        n_checks++;
        if (cdb_cnt - c0 !== 1) begin
            n_fail++;
            $display("FAIL conflict_flush_reads: got %0d expected 1", cdb_cnt - c0);
        end
        n_checks++;
        if (pushes.size() !== 0) begin
            n_fail++;
            $display("FAIL conflict_push_count: got %0d expected 0", pushes.size());
        end
        reset_bcp = 1'b1;
        @(posedge clock); #1;
        reset_bcp = 1'b0;
        n_checks++;
        if (conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_cleared: got %b expected 0", conflict);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        pushes.delete();
        bad_push = 0;
        full_imply = 1'b1;
        send_one(8'd16);
        repeat (8) @(posedge clock);
        #1;
        for (int unsigned i = 0; i < 16; i++) begin
            bcp_en = 1'b1;
            bcp_clause_idx = 8'(17 + i);
            @(posedge clock); #1;
        end
        n_checks++;
        if (q_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_no_overflow: got %b expected 0", q_overflow);
        end
        bcp_clause_idx = 8'd33;
        @(posedge clock); #1;
        bcp_en = 1'b0;
        n_checks++;
        if (q_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_overflow: got %b expected 1", q_overflow);
        end
        n_checks++;
        if (pushes.size() !== 0) begin
            n_fail++;
            $display("FAIL b2b_stalled_pushes: got %0d expected 0", pushes.size());
        end
        repeat (5) @(posedge clock);
        #1;
        full_imply = 1'b0;
        wait_idle(500, n);
        n_checks++;
        if (bcp_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_timeout: busy got %b expected 0", bcp_busy);
        end
        n_checks++;
        if (pushes.size() !== 17) begin
            n_fail++;
            $display("FAIL b2b_push_count: got %0d expected 17", pushes.size());
        end else begin
            for (int unsigned i = 0; i < 17; i++) begin
                logic [7:0] c;
                c = 8'(16 + i);
                n_checks++;
                if (pushes[i] !== {1'b1, ~c[0], c + 8'd100}) begin
                    n_fail++;
                    $display("FAIL b2b_order[%0d]: got %h expected %h", i, pushes[i], {1'b1, ~c[0], c + 8'd100});
                end
            end
        end
        n_checks++;
        if (bad_push !== 0) begin
            n_fail++;
            $display("FAIL b2b_push_while_full: got %0d expected 0", bad_push);
        end
    endtask

    task automatic test_resets;
        int n;
        pushes.delete();
        send_one(8'd1);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset_bcp = 1'b1;
        @(posedge clock); #1;
        reset_bcp = 1'b0;
        n_checks++;
        if ({bcp_busy, conflict, q_overflow} !== 3'b000) begin
            n_fail++;
            $display("FAIL rbcp_state: busy/conflict/ovf got %b expected 000", {bcp_busy, conflict, q_overflow});
        end
        repeat (15) @(posedge clock);
        #1;
        n_checks++;
        if (pushes.size() !== 0) begin
            n_fail++;
            $display("FAIL rbcp_no_push: got %0d expected 0", pushes.size());
        end
        full_imply = 1'b1;
        send_one(8'd1);
        repeat (12) @(posedge clock);
        #1;
        n_checks++;
        if ({type_in_imply, var_in_imply, push_imply} !== {1'b1, 8'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL push_hold: got %h expected %h", {type_in_imply, var_in_imply, push_imply}, {1'b1, 8'd3, 1'b0});
        end
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({bcp_busy, conflict, q_overflow, cdb_read, vs_read, push_imply, var_in_imply,
             val_in_imply, type_in_imply} !== 16'h0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got %h expected 0000",
                     {bcp_busy, conflict, q_overflow, cdb_read, vs_read, push_imply, var_in_imply,
                      val_in_imply, type_in_imply});
        end
        @(posedge clock); #1;
        reset = 1'b1;
        full_imply = 1'b0;
        wait_idle(20, n);
        repeat (5) @(posedge clock);
        #1;
        n_checks++;
        if ({pushes.size() == 0, bcp_busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_abandon: pushes %0d busy %b expected 0 pushes, busy 0", pushes.size(), bcp_busy);
        end
    endtask

    initial begin
        reset = 1'b0;
        reset_bcp = 1'b0;
        bcp_en = 1'b0;
        bcp_clause_idx = '0;
        full_imply = 1'b0;
        cdb_lits = '0;
        vs_val = 1'b0;
        vs_unassign = 1'b0;
        vs_cnt = 0;
        cdb_cnt = 0;
        bad_push = 0;
        n_checks = 0;
        n_fail = 0;
        for (int unsigned i = 0; i < 256; i++) begin
            db[i] = '0;
            var_val[i] = 1'b0;
            var_un[i] = 1'b1;
        end
        db[1] = {lit(1'b1, 1'b0, 8'd3), lit(1'b1, 1'b1, 8'd2), lit(1'b1, 1'b0, 8'd1)};
        db[2] = {lit(1'b0, 1'b0, 8'd0), lit(1'b1, 1'b0, 8'd2), lit(1'b1, 1'b0, 8'd1)};
        db[3] = {lit(1'b1, 1'b0, 8'd6), lit(1'b1, 1'b0, 8'd5), lit(1'b1, 1'b0, 8'd4)};
        for (int unsigned c = 16; c < 34; c++) begin
            logic [7:0] cb;
            cb = 8'(c);
            db[c] = {20'h0, lit(1'b1, cb[0], cb + 8'd100)};
        end
        var_un[1] = 1'b0; var_val[1] = 1'b0;
        var_un[2] = 1'b0; var_val[2] = 1'b1;
        var_un[4] = 1'b0; var_val[4] = 1'b1;

        test_reset;
        test_unit_push;
        test_satisfied;
        var_val[2] = 1'b0;
        test_conflict;
        var_val[2] = 1'b1;
        test_back_to_back;
        test_resets;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
